// File: rtl/mips_ni_bridge.sv
`default_nettype none
// ============================================================================
// mips_ni_bridge : TX FIFO and RX holding register between the MIPS core and the NoC NI
// Revision       : 1.0
// ============================================================================
module mips_ni_bridge #(
    parameter int          DATA_W   = 32,
    parameter int          TX_DEPTH = 4,
    parameter logic [1:0]  SRC_ADDR = 2'b00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              proc_valid,
    input  logic [1:0]        dest_add,
    input  logic [DATA_W-1:0] proc_data,
    output logic              mips_ni,
    output logic              ni_tx_valid,
    input  logic              ni_tx_ready,
    output logic [1:0]        ni_tx_dest,
    output logic [1:0]        ni_tx_src,
    output logic [DATA_W-1:0] ni_tx_data,
    input  logic              ni_rx_valid,
    input  logic [1:0]        ni_rx_src,
    input  logic [DATA_W-1:0] ni_rx_data,
    output logic              ni_rx_ready,
    output logic              data_valid,
    output logic [1:0]        rx_src,
    output logic [DATA_W-1:0] rx_data,
    input  logic              reg_en,
    output logic [15:0]       tx_sent_cnt
);

    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(TX_DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);

    localparam logic [0:0] RX_EMPTY = 1'b0;
    localparam logic [0:0] RX_FULL  = 1'b1;

    logic [1:0]        dest_mem_q [TX_DEPTH];
    logic [1:0]        dest_mem_d [TX_DEPTH];
    logic [DATA_W-1:0] data_mem_q [TX_DEPTH];
    logic [DATA_W-1:0] data_mem_d [TX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       sent_q, sent_d;

    logic              tx_push;
    logic              tx_pop;

    logic [0:0]        rx_state_q, rx_state_d;
    logic [1:0]        rx_src_q, rx_src_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_capture;

    // ---------------- TX FIFO ----------------
    assign mips_ni     = (count_q != C_CNT_FULL);
    assign ni_tx_valid = (count_q != '0);
    assign ni_tx_dest  = dest_mem_q[rd_ptr_q];
    assign ni_tx_data  = data_mem_q[rd_ptr_q];
    assign ni_tx_src   = SRC_ADDR;
    assign tx_sent_cnt = sent_q;

    assign tx_push = proc_valid && mips_ni;
    assign tx_pop  = ni_tx_valid && ni_tx_ready;

    always_comb begin
        dest_mem_d = dest_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        sent_d     = sent_q;
        if (tx_push) begin
            dest_mem_d[wr_ptr_q] = dest_add;
            data_mem_d[wr_ptr_q] = proc_data;
            wr_ptr_d             = wr_ptr_q + C_PTR_ONE;
        end
        if (tx_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            sent_d   = sent_q + 16'd1;
        end
        case ({tx_push, tx_pop})
            2'b10:   count_d = count_q + C_CNT_ONE;
            2'b01:   count_d = count_q - C_CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head outputs read zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TX_DEPTH; i++) begin
                dest_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sent_q   <= '0;
        end else begin
            dest_mem_q <= dest_mem_d;
            data_mem_q <= data_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sent_q     <= sent_d;
        end
    end

    // ---------------- RX holding register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_EMPTY;
            rx_src_q   <= '0;
            rx_data_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_src_q   <= rx_src_d;
            rx_data_q  <= rx_data_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_EMPTY: if (ni_rx_valid)            rx_state_d = RX_FULL;
            RX_FULL:  if (reg_en && !ni_rx_valid) rx_state_d = RX_EMPTY;
            default:                              rx_state_d = RX_EMPTY;
        endcase
    end

    // Consuming and refilling in the same cycle keeps one word per cycle flowing.
    always_comb begin
        data_valid  = (rx_state_q == RX_FULL);
        ni_rx_ready = (rx_state_q == RX_EMPTY) || reg_en;
        rx_capture  = ni_rx_valid && ni_rx_ready;
        rx_src_d    = rx_capture ? ni_rx_src  : rx_src_q;
        rx_data_d   = rx_capture ? ni_rx_data : rx_data_q;
    end

    assign rx_src  = rx_src_q;
    assign rx_data = rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_ni_bridge.sv
`default_nettype none
// ============================================================================
// tb_mips_ni_bridge : randomized and directed bench against a queue-based model
// Revision          : 1.0
// ============================================================================
module tb_mips_ni_bridge;

    localparam int         DATA_W   = 32;
    localparam int         TX_DEPTH = 4;
    localparam logic [1:0] SRC_ADDR = 2'b10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              proc_valid = 1'b0;
    logic [1:0]        dest_add = '0;
    logic [DATA_W-1:0] proc_data = '0;
    logic              mips_ni;
    logic              ni_tx_valid;
    logic              ni_tx_ready = 1'b0;
    logic [1:0]        ni_tx_dest;
    logic [1:0]        ni_tx_src;
    logic [DATA_W-1:0] ni_tx_data;
    logic              ni_rx_valid = 1'b0;
    logic [1:0]        ni_rx_src = '0;
    logic [DATA_W-1:0] ni_rx_data = '0;
    logic              ni_rx_ready;
    logic              data_valid;
    logic [1:0]        rx_src;
    logic [DATA_W-1:0] rx_data;
    logic              reg_en = 1'b0;
    logic [15:0]       tx_sent_cnt;

    mips_ni_bridge #(.DATA_W(DATA_W), .TX_DEPTH(TX_DEPTH), .SRC_ADDR(SRC_ADDR)) dut (
        .clk(clk), .rst(rst),
        .proc_valid(proc_valid), .dest_add(dest_add), .proc_data(proc_data),
        .mips_ni(mips_ni),
        .ni_tx_valid(ni_tx_valid), .ni_tx_ready(ni_tx_ready),
        .ni_tx_dest(ni_tx_dest), .ni_tx_src(ni_tx_src), .ni_tx_data(ni_tx_data),
        .ni_rx_valid(ni_rx_valid), .ni_rx_src(ni_rx_src), .ni_rx_data(ni_rx_data),
        .ni_rx_ready(ni_rx_ready),
        .data_valid(data_valid), .rx_src(rx_src), .rx_data(rx_data),
        .reg_en(reg_en), .tx_sent_cnt(tx_sent_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {dest,data}, a held-word flag and a pop counter.
    logic [DATA_W+1:0] m_q[$];
    bit                m_tx_fresh = 1'b1;
    bit                m_held     = 1'b0;
    bit                m_rx_fresh = 1'b1;
    logic [1:0]        m_rx_src   = '0;
    logic [DATA_W-1:0] m_rx_data  = '0;
    logic [15:0]       m_sent     = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_tx_fresh = 1'b1;
            m_held     = 1'b0;
            m_rx_fresh = 1'b1;
            m_rx_src   = '0;
            m_rx_data  = '0;
            m_sent     = '0;
        end else begin
            bit do_pop, do_push;
            do_pop  = (m_q.size() != 0) && ni_tx_ready;
            do_push = proc_valid && (m_q.size() != TX_DEPTH);
            if (do_pop) begin
                void'(m_q.pop_front());
                m_sent = m_sent + 16'd1;
            end
            if (do_push) begin
                m_q.push_back({dest_add, proc_data});
                m_tx_fresh = 1'b0;
            end
            if (ni_rx_valid && (!m_held || reg_en)) begin
                m_held     = 1'b1;
                m_rx_fresh = 1'b0;
                m_rx_src   = ni_rx_src;
                m_rx_data  = ni_rx_data;
            end else if (m_held && reg_en) begin
                m_held = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("mips_ni", 64'(mips_ni), 64'(m_q.size() != TX_DEPTH));
            check("ni_tx_valid", 64'(ni_tx_valid), 64'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                check("ni_tx_dest", 64'(ni_tx_dest), 64'(m_q[0][DATA_W+1:DATA_W]));
                check("ni_tx_data", 64'(ni_tx_data), 64'(m_q[0][DATA_W-1:0]));
            end else if (m_tx_fresh) begin
                check("ni_tx_dest_rst", 64'(ni_tx_dest), 64'd0);
                check("ni_tx_data_rst", 64'(ni_tx_data), 64'd0);
            end
            check("ni_tx_src", 64'(ni_tx_src), 64'(SRC_ADDR));
            check("ni_rx_ready", 64'(ni_rx_ready), 64'(!m_held || reg_en));
            check("data_valid", 64'(data_valid), 64'(m_held));
            if (m_held || m_rx_fresh) begin
                check("rx_src", 64'(rx_src), 64'(m_rx_src));
                check("rx_data", 64'(rx_data), 64'(m_rx_data));
            end
            check("tx_sent_cnt", 64'(tx_sent_cnt), 64'(m_sent));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        proc_valid  = 1'b0;
        ni_tx_ready = 1'b0;
        ni_rx_valid = 1'b0;
        reg_en      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        check("lit_rst_mips_ni", 64'(mips_ni), 64'd1);
        check("lit_rst_tx_valid", 64'(ni_tx_valid), 64'd0);
        check("lit_rst_rx_ready", 64'(ni_rx_ready), 64'd1);
        check("lit_rst_data_valid", 64'(data_valid), 64'd0);
        check("lit_rst_sent", 64'(tx_sent_cnt), 64'd0);
        check("lit_rst_src", 64'(ni_tx_src), 64'(SRC_ADDR));

        // Fill with the NI stalled
        step();
        for (int i = 0; i < 4; i++) begin
            proc_valid = 1'b1;
            dest_add   = 2'((i + 1) % 4);
            proc_data  = 32'hA0 + 32'(i);
            step();
        end
        @(negedge clk);
        check("lit_full_mips_ni", 64'(mips_ni), 64'd0);
        proc_data = 32'hFF;
        dest_add  = 2'd3;
        step();
        proc_valid  = 1'b0;
        ni_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("lit_drain_data", 64'(ni_tx_data), 64'hA0 + 64'(i));
            check("lit_drain_dest", 64'(ni_tx_dest), 64'((i + 1) % 4));
            step();
            if (i == 0) check("lit_mips_ni_after_pop", 64'(mips_ni), 64'd1);
        end
        @(negedge clk);
        check("lit_sent4", 64'(tx_sent_cnt), 64'd4);
        check("lit_empty_after_drain", 64'(ni_tx_valid), 64'd0);

        // Steady stream, wrapping the pointers
        step();
        for (int i = 0; i < 10; i++) begin
            proc_valid = 1'b1;
            dest_add   = 2'(i % 4);
            proc_data  = 32'hB0 + 32'(i);
            step();
        end
        proc_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        check("lit_sent14", 64'(tx_sent_cnt), 64'd14);

        // RX back-pressure
        step();
        ni_tx_ready = 1'b0;
        ni_rx_valid = 1'b1;
        ni_rx_src   = 2'd2;
        ni_rx_data  = 32'h55;
        step();
        @(negedge clk);
        check("lit_rx_dv", 64'(data_valid), 64'd1);
        check("lit_rx_data55", 64'(rx_data), 64'h55);
        check("lit_rx_src2", 64'(rx_src), 64'd2);
        step();
        ni_rx_src  = 2'd1;
        ni_rx_data = 32'h66;
        #1;
        check("lit_rx_ready_blocked", 64'(ni_rx_ready), 64'd0);
        step();
        check("lit_rx_held55", 64'(rx_data), 64'h55);
        reg_en = 1'b1;
        #1;
        check("lit_rx_ready_regen", 64'(ni_rx_ready), 64'd1);
        step();
        reg_en      = 1'b0;
        ni_rx_valid = 1'b0;
        @(negedge clk);
        check("lit_rx_data66", 64'(rx_data), 64'h66);
        check("lit_rx_dv_stays", 64'(data_valid), 64'd1);

        // Reset mid-operation
        step();
        for (int i = 0; i < 3; i++) begin
            proc_valid = 1'b1;
            dest_add   = 2'(i);
            proc_data  = 32'hC0 + 32'(i);
            step();
        end
        proc_valid = 1'b0;
        do_reset();
        @(negedge clk);
        check("lit_rst2_tx_valid", 64'(ni_tx_valid), 64'd0);
        check("lit_rst2_dv", 64'(data_valid), 64'd0);
        check("lit_rst2_sent", 64'(tx_sent_cnt), 64'd0);
        check("lit_rst2_rx_data", 64'(rx_data), 64'd0);
        step();
        proc_valid = 1'b1;
        dest_add   = 2'd1;
        proc_data  = 32'hD0;
        step();
        proc_valid = 1'b0;
        @(negedge clk);
        check("lit_rst2_push", 64'(ni_tx_data), 64'hD0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            step();
            rst         = ($urandom_range(0, 199) == 0);
            proc_valid  = 1'($urandom_range(0, 2) != 0);
            dest_add    = 2'($urandom);
            proc_data   = $urandom;
            ni_tx_ready = 1'($urandom_range(0, 1));
            ni_rx_valid = 1'($urandom_range(0, 1));
            ni_rx_src   = 2'($urandom);
            ni_rx_data  = $urandom;
            reg_en      = 1'($urandom_range(0, 1));
        end

        // Counter wrap: 65536 pops
        do_reset();
        step();
        ni_tx_ready = 1'b1;
        proc_valid  = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            dest_add  = 2'(i);
            proc_data = 32'(i);
            step();
        end
        proc_valid = 1'b0;
        @(negedge clk);
        check("lit_sent_ffff", 64'(tx_sent_cnt), 64'hFFFF);
        step();
        @(negedge clk);
        check("lit_sent_wrap", 64'(tx_sent_cnt), 64'd0);

        idle_inputs();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
